// File: rtl/axis_frame_pad.sv
// AXI-Stream frame padder: appends zero beats so each frame's length is a multiple
// of PAD_BEATS. Output register stage with one-beat latency.
module axis_frame_pad #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int PAD_BEATS  = 4,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  localparam int CNT_WIDTH = (PAD_BEATS > 1) ? $clog2(PAD_BEATS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(PAD_BEATS - 1);

  typedef enum logic {PASS = 1'b0, PAD = 1'b1} state_t;

  state_t                state, state_next;
  logic [CNT_WIDTH-1:0]  cnt, cnt_next, cnt_wrap;
  logic [ID_WIDTH-1:0]   pad_id, pad_id_next;
  logic [DEST_WIDTH-1:0] pad_dest, pad_dest_next;
  logic [USER_WIDTH-1:0] pad_user, pad_user_next;

  logic [DATA_WIDTH-1:0] data_next;
  logic [KEEP_WIDTH-1:0] keep_next;
  logic                  valid_next, last_next;
  logic [ID_WIDTH-1:0]   id_next;
  logic [DEST_WIDTH-1:0] dest_next;
  logic [USER_WIDTH-1:0] user_next;

  logic load_ok, accept;

  // Both ports use standard valid/ready: a beat moves on a rising edge where valid
  // and ready are both high; a valid beat holds all its fields until it moves.
  assign load_ok       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = !rst && (state == PASS) && load_ok;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign cnt_wrap      = (cnt == CNT_LAST) ? '0 : cnt + CNT_WIDTH'(1);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    pad_id_next   = pad_id;
    pad_dest_next = pad_dest;
    pad_user_next = pad_user;
    data_next     = m_axis_tdata;
    keep_next     = m_axis_tkeep;
    valid_next    = m_axis_tvalid;
    last_next     = m_axis_tlast;
    id_next       = m_axis_tid;
    dest_next     = m_axis_tdest;
    user_next     = m_axis_tuser;

    case (state)
      PASS: begin
        if (accept) begin
          data_next  = s_axis_tdata;
          keep_next  = s_axis_tkeep;
          valid_next = 1'b1;
          id_next    = s_axis_tid;
          dest_next  = s_axis_tdest;
          user_next  = s_axis_tuser;
          if (!s_axis_tlast) begin
            last_next = 1'b0;
            cnt_next  = cnt_wrap;
          end else if (cnt == CNT_LAST) begin
            last_next = 1'b1;
            cnt_next  = '0;
          end else begin
            // Short frame: hold back tlast and remember the sideband for the pad beats.
            last_next     = 1'b0;
            pad_id_next   = s_axis_tid;
            pad_dest_next = s_axis_tdest;
            pad_user_next = s_axis_tuser;
            cnt_next      = cnt + CNT_WIDTH'(1);
            state_next    = PAD;
          end
        end else if (m_axis_tready) begin
          valid_next = 1'b0;
        end
      end
      PAD: begin
        if (load_ok) begin
          data_next  = '0;
          keep_next  = '1;
          valid_next = 1'b1;
          id_next    = pad_id;
          dest_next  = pad_dest;
          user_next  = pad_user;
          last_next  = (cnt == CNT_LAST);
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            state_next = PASS;
          end else begin
            cnt_next = cnt + CNT_WIDTH'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PASS;
      cnt           <= '0;
      pad_id        <= '0;
      pad_dest      <= '0;
      pad_user      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      pad_id        <= pad_id_next;
      pad_dest      <= pad_dest_next;
      pad_user      <= pad_user_next;
      m_axis_tdata  <= data_next;
      m_axis_tkeep  <= keep_next;
      m_axis_tvalid <= valid_next;
      m_axis_tlast  <= last_next;
      m_axis_tid    <= id_next;
      m_axis_tdest  <= dest_next;
      m_axis_tuser  <= user_next;
    end
  end

endmodule

// File: tb/tb_axis_frame_pad.sv
// Bench for axis_frame_pad: table of frame scenarios, hand sequences for back-to-back
// frames and reset mid-pad, then random frames against a frame-level padding model.
module tb_axis_frame_pad;
  localparam int DW  = 32;
  localparam int KW  = DW/8;
  localparam int P   = 4;
  localparam int IW  = 8;
  localparam int DSW = 8;
  localparam int UW  = 1;
  localparam int BW  = DW + KW + 1 + IW + DSW + UW;

  logic          clk, rst;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [IW-1:0] s_axis_tid;
  logic [DSW-1:0] s_axis_tdest;
  logic [UW-1:0] s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [IW-1:0] m_axis_tid;
  logic [DSW-1:0] m_axis_tdest;
  logic [UW-1:0] m_axis_tuser;

  axis_frame_pad #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .PAD_BEATS(P),
    .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser)
  );

  // ---------------- clock / reset / ready generator ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rdy_mode = 0;  // 0: always ready, 1: alternate 1,0,1,0, 2: random
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check bookkeeping ----------------
  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [BW-1:0] pack_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                                input logic l, input logic [IW-1:0] i,
                                                input logic [DSW-1:0] ds, input logic [UW-1:0] u);
    return {d, k, l, i, ds, u};
  endfunction

  // ---------------- monitor (observes only) ----------------
  logic [BW-1:0] out_beat;
  assign out_beat = pack_beat(m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid,
                              m_axis_tdest, m_axis_tuser);

  logic [BW-1:0] got_q[$];
  logic [BW:0]   stab_prev_q[$];
  logic [BW:0]   stab_cur_q[$];
  logic          prev_stall = 1'b0;
  logic [BW:0]   prev_beat = '0;
  int out_beats = 0, out_lasts = 0, notready_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        stab_prev_q.push_back(prev_beat);
        stab_cur_q.push_back({m_axis_tvalid, out_beat});
      end
      prev_stall <= m_axis_tvalid && !m_axis_tready;
      prev_beat  <= {m_axis_tvalid, out_beat};
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(out_beat);
        out_beats <= out_beats + 1;
        if (m_axis_tlast) out_lasts <= out_lasts + 1;
      end
      if (!s_axis_tready) notready_cnt <= notready_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int rd_idx = 0;
  int stab_idx = 0;

  task automatic compare_pending();
    while (rd_idx < got_q.size()) begin
      check("sb_expected_available", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sb_beat", got_q[rd_idx], exp_q.pop_front());
      rd_idx++;
    end
    while (stab_idx < stab_cur_q.size()) begin
      check("stall_stable", stab_cur_q[stab_idx], stab_prev_q[stab_idx]);
      stab_idx++;
    end
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while (((got_q.size() - rd_idx) < exp_q.size()) && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (6) @(negedge clk);
    compare_pending();
    check({tag, "_missing_beats"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver + frame-level reference model ----------------
  // Model: every input beat passes through unchanged except that tlast moves to the
  // end of the padded frame; pads = (P - L mod P) mod P zero beats with full tkeep
  // and the last input beat's sideband.
  task automatic send_frame(input int len, input bit rnd, input logic [KW-1:0] keep_last,
                            input logic [UW-1:0] user, input logic [IW-1:0] id0,
                            input bit gaps, output int nout);
    logic [DW-1:0]  d_a[16];
    logic [KW-1:0]  k_a[16];
    logic [IW-1:0]  i_a[16];
    logic [DSW-1:0] ds_a[16];
    logic [UW-1:0]  u_a[16];
    int pads;
    bit got;
    for (int i = 0; i < len; i++) begin
      d_a[i]  = rnd ? DW'($urandom) : DW'(32'h1111_1111 * (i + 1));
      k_a[i]  = (i == len - 1) ? keep_last : '1;
      i_a[i]  = rnd ? IW'($urandom) : IW'(id0 + IW'(i));
      ds_a[i] = rnd ? DSW'($urandom) : DSW'(id0 ^ 8'h5A);
      u_a[i]  = rnd ? UW'($urandom) : user;
    end
    pads = (P - (len % P)) % P;
    for (int i = 0; i < len; i++)
      exp_q.push_back(pack_beat(d_a[i], k_a[i], (i == len - 1) && (pads == 0), i_a[i], ds_a[i], u_a[i]));
    for (int j = 0; j < pads; j++)
      exp_q.push_back(pack_beat('0, '1, j == pads - 1, i_a[len-1], ds_a[len-1], u_a[len-1]));
    nout = len + pads;

    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      s_axis_tdata  = d_a[i];
      s_axis_tkeep  = k_a[i];
      s_axis_tlast  = (i == len - 1);
      s_axis_tid    = i_a[i];
      s_axis_tdest  = ds_a[i];
      s_axis_tuser  = u_a[i];
      s_axis_tvalid = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 300 && !got; w++) begin
        @(negedge clk);
        got = s_axis_tready;
      end
      check("in_handshake", got, 1);
      @(posedge clk);
      #1;
      check("latency_valid", m_axis_tvalid, 1);
      check("latency_data", m_axis_tdata, d_a[i]);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // ---------------- test table ----------------
  typedef struct {
    string          name;
    int             len;
    logic [KW-1:0]  keep_last;
    logic [UW-1:0]  user;
    logic [IW-1:0]  id0;
    int             rdy;
    int             exp_beats;
    int             exp_lasts;
    int             exp_stall;  // cycles with s_axis_tready low; -1 when backpressure mixes in
  } vec_t;

  vec_t vecs[5];

  initial begin
    int b0, l0, n0, c0, nout, total;

    vecs[0] = '{"aligned",  4, 4'hF, 1'b0, 8'h10, 0, 4, 1, 0};
    vecs[1] = '{"five",     5, 4'hF, 1'b0, 8'h20, 0, 8, 1, 3};
    vecs[2] = '{"one",      1, 4'h3, 1'b1, 8'h30, 0, 4, 1, 3};
    vecs[3] = '{"five_bp",  5, 4'hF, 1'b0, 8'h40, 1, 8, 1, -1};
    vecs[4] = '{"seven_rr", 7, 4'hC, 1'b1, 8'h50, 2, 8, 1, -1};

    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    s_axis_tid = '0; s_axis_tdest = '0; s_axis_tuser = '0;
    s_axis_tvalid = 1'b1;
    rst = 1'b1;

    // reset state, with an input beat offered that must not be taken
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tdata",  m_axis_tdata, 0);
    check("rst_m_tkeep",  m_axis_tkeep, 0);
    check("rst_m_tlast",  m_axis_tlast, 0);
    check("rst_m_tid",    m_axis_tid, 0);
    check("rst_m_tdest",  m_axis_tdest, 0);
    check("rst_m_tuser",  m_axis_tuser, 0);
    s_axis_tvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", s_axis_tready, 1);
    check("idle_m_tvalid", m_axis_tvalid, 0);

    for (int t = 0; t < 5; t++) begin
      rdy_mode = vecs[t].rdy;
      @(posedge clk);
      #1;
      b0 = out_beats; l0 = out_lasts; n0 = notready_cnt;
      send_frame(vecs[t].len, 1'b0, vecs[t].keep_last, vecs[t].user, vecs[t].id0, 1'b0, nout);
      drain(vecs[t].name);
      check($sformatf("%s_beats", vecs[t].name), out_beats - b0, vecs[t].exp_beats);
      check($sformatf("%s_lasts", vecs[t].name), out_lasts - l0, vecs[t].exp_lasts);
      if (vecs[t].exp_stall >= 0)
        check($sformatf("%s_stall_cycles", vecs[t].name), notready_cnt - n0, vecs[t].exp_stall);
    end

    // back-to-back 3-beat then 4-beat frames with no idle between them
    rdy_mode = 0;
    @(posedge clk);
    #1;
    b0 = out_beats; l0 = out_lasts; n0 = notready_cnt; c0 = cyc;
    send_frame(3, 1'b0, 4'hF, 1'b0, 8'h60, 1'b0, nout);
    send_frame(4, 1'b0, 4'hF, 1'b1, 8'h70, 1'b0, nout);
    check("b2b_accept_cycles", cyc - c0, 8);
    drain("b2b");
    check("b2b_beats", out_beats - b0, 8);
    check("b2b_lasts", out_lasts - l0, 2);
    check("b2b_stall_cycles", notready_cnt - n0, 1);

    // reset after two pad beats of a five-beat frame
    send_frame(5, 1'b0, 4'hF, 1'b0, 8'h80, 1'b0, nout);
    repeat (2) @(posedge clk);
    #1;
    check("midpad_tvalid", m_axis_tvalid, 1);
    check("midpad_tdata", m_axis_tdata, 0);
    rst = 1'b1;
    #1;
    check("midpad_rst_s_tready", s_axis_tready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("after_rst_m_tvalid", m_axis_tvalid, 0);
    compare_pending();
    exp_q.delete();
    b0 = out_beats; l0 = out_lasts;
    send_frame(4, 1'b0, 4'hF, 1'b0, 8'h90, 1'b0, nout);
    drain("post_rst");
    check("post_rst_beats", out_beats - b0, 4);
    check("post_rst_lasts", out_lasts - l0, 1);

    // random frames, random gaps, random backpressure
    rdy_mode = 2;
    total = 0;
    b0 = out_beats; l0 = out_lasts;
    for (int f = 0; f < 40; f++) begin
      send_frame($urandom_range(1, 9), 1'b1, KW'($urandom_range(1, 15)), '0, '0, 1'b1, nout);
      total += nout;
    end
    drain("random");
    check("random_beats", out_beats - b0, total);
    check("random_lasts", out_lasts - l0, 40);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
